// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N_CH producers, the mux, and one consumer.
// The slave modport is the mux side; master is the producer/consumer side.
interface stream_mux_rr_if #(
  parameter int N_CH = 4,
  parameter int W    = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [N_CH*W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux: fixed-select or round-robin grant,
// followed by a single output register that holds under backpressure.
module stream_mux_rr #(
    parameter  int N_CH  = 4,
    parameter  int W     = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    stream_mux_rr_if.slave   bus
);
    localparam int PAD_N = 1 << SEL_W;

    logic [N_CH-1:0][W-1:0] ch_data;
    logic [PAD_N-1:0]       vld_pad;
    logic                   load_en;
    logic                   gnt_vld;
    logic [SEL_W-1:0]       gnt_idx;
    logic [N_CH-1:0]        in_ready_c;
    int                     idx;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*W +: W];
    end

    assign load_en = !out_valid_q || bus.out_ready;

    // Padding in_valid up to a power of two makes an out-of-range sel read a 0.
    always_comb begin
        vld_pad           = '0;
        vld_pad[N_CH-1:0] = bus.in_valid;
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (rst_n) begin
            if (!mode) begin
                gnt_vld = vld_pad[sel];
                gnt_idx = sel;
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    idx = (int'(ptr_q) + k) % N_CH;
                    if (!gnt_vld && bus.in_valid[idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SEL_W'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready_c = '0;
        for (int i = 0; i < N_CH; i++)
            in_ready_c[i] = load_en && gnt_vld && (gnt_idx == SEL_W'(i));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = ch_data[gnt_idx];
                out_ch_d   = gnt_idx;
                if (mode)
                    ptr_d = (gnt_idx == SEL_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule
